csa_resolver: RTL and testbench

Multi-cycle carry-propagate resolver that converts a carry-save pair (sum vector u, carry vector v) into a single binary result. It sits after the carry-save compression stages of the configurable multiplier and produces the final product word. The addition runs over CHUNK_SIZE-bit slices, one slice per cycle, which trades latency for a short carry chain. Operands enter and results leave through valid/ready handshakes.

---
 rtl/csa_resolver_pkg.sv | 25 ++
 rtl/csa_resolver_if.sv | 30 +++
 rtl/csa_resolver_cpa_chunk.sv | 53 +++++
 rtl/csa_resolver.sv | 130 +++++++++++++
 tb/tb_csa_resolver.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_resolver_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the carry-save resolver:
//   state_t   - resolver FSM states (IDLE, RUN, DONE)
//   nchunk    - number of CHUNK_SIZE slices needed to cover DATA_SIZE+1 bits
//   cnt_width - width of the chunk counter, never less than one bit
// ---------------------------------------------------------------------------
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int data_size, input int chunk_size);
    return (data_size + 1 + chunk_size - 1) / chunk_size;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// ---------------------------------------------------------------------------
// csa_resolver_if
// Operand and result handshakes of the carry-save resolver.
//   valid_i/ready_o/u_i/v_i   - operand channel (into the resolver)
//   valid_o/ready_i/sum_o     - result channel (out of the resolver)
// Modports: slave = resolver side, master = source/sink side.
// ---------------------------------------------------------------------------
interface csa_resolver_if #(
  parameter int DATA_SIZE = 8
);

  logic                 valid_i;
  logic                 ready_o;
  logic [DATA_SIZE-1:0] u_i;
  logic [DATA_SIZE:0]   v_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DATA_SIZE+1:0] sum_o;

  modport slave (
    input  valid_i, u_i, v_i, ready_i,
    output ready_o, valid_o, sum_o
  );

  modport master (
    output valid_i, u_i, v_i, ready_i,
    input  ready_o, valid_o, sum_o
  );

endinterface

// File: rtl/csa_resolver_cpa_chunk.sv
// ---------------------------------------------------------------------------
// fulladder
// One-bit full adder cell.
//   a, b, ci - addends and carry in
//   s, co    - sum and carry out
// ---------------------------------------------------------------------------
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// ---------------------------------------------------------------------------
// cpa_chunk
// Combinational WIDTH-bit ripple-carry adder built from fulladder cells.
//   a_i, b_i  - slice operands
//   carry_i   - carry into bit 0
//   sum_o     - slice sum
//   carry_o   - carry out of the top bit
// ---------------------------------------------------------------------------
module cpa_chunk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = carry_i;
  assign carry_o  = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fulladder u_fa (
      .a  (a_i[i]),
      .b  (b_i[i]),
      .ci (carry[i]),
      .s  (sum_o[i]),
      .co (carry[i+1])
    );
  end

endmodule

// File: rtl/csa_resolver.sv
// ---------------------------------------------------------------------------
// csa_resolver
// Resolves a carry-save pair (u, v) into a binary sum, CHUNK_SIZE bits per
// cycle, using one shared cpa_chunk and a carry flop between slices.
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - operand/result handshakes (csa_resolver_if.slave)
// Latency is NCHUNK cycles from accept to valid_o.
// ---------------------------------------------------------------------------
module csa_resolver
  import csa_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int CHUNK_SIZE = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  csa_resolver_if.slave   bus
);

  localparam int NCHUNK = nchunk(DATA_SIZE, CHUNK_SIZE);
  localparam int CW     = cnt_width(NCHUNK);
  localparam int PW     = NCHUNK * CHUNK_SIZE;
  localparam int FW     = PW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic                  carry_q;
  logic [PW-1:0]         u_q;
  logic [PW-1:0]         v_q;
  logic [PW-1:0]         result_q;

  logic [CHUNK_SIZE-1:0] u_slice;
  logic [CHUNK_SIZE-1:0] v_slice;
  logic [CHUNK_SIZE-1:0] chunk_sum;
  logic                  chunk_carry;

  // The carry flop sits above the result so that a layout with
  // PW == DATA_SIZE+1 still delivers the top sum bit.
  logic [FW-1:0]         full_result;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_i)        state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT)  state_d = DONE;
      DONE:    if (bus.ready_i)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Counter-indexed slice select feeding the shared adder.
  always_comb begin
    u_slice = '0;
    v_slice = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        u_slice = u_q[i*CHUNK_SIZE +: CHUNK_SIZE];
        v_slice = v_q[i*CHUNK_SIZE +: CHUNK_SIZE];
      end
    end
  end

  cpa_chunk #(
    .WIDTH (CHUNK_SIZE)
  ) u_cpa_chunk (
    .a_i     (u_slice),
    .b_i     (v_slice),
    .carry_i (carry_q),
    .sum_o   (chunk_sum),
    .carry_o (chunk_carry)
  );

  // Operand capture, per-slice accumulation and carry/counter update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      u_q      <= '0;
      v_q      <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            u_q     <= PW'(bus.u_i);
            v_q     <= PW'(bus.v_i);
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
              result_q[i*CHUNK_SIZE +: CHUNK_SIZE] <= chunk_sum;
            end
          end
          carry_q <= chunk_carry;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign full_result = {carry_q, result_q};

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.sum_o   = full_result[DATA_SIZE+1:0];

  // Padding bits above the exact sum width are always zero and dropped.
  if (FW > DATA_SIZE + 2) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^full_result[FW-1:DATA_SIZE+2];
  end

endmodule

// File: tb/tb_csa_resolver.sv
// ---------------------------------------------------------------------------
// tb_csa_resolver
// Directed and random self-checking bench for csa_resolver at the default
// parameters (DATA_SIZE=8, CHUNK_SIZE=4, NCHUNK=3). Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_csa_resolver;

  localparam int DATA_SIZE = 8;
  localparam int TIMEOUT   = 50;
  localparam int N_RANDOM  = 6000;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  csa_resolver_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  csa_resolver #(
    .DATA_SIZE  (DATA_SIZE),
    .CHUNK_SIZE (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair, wait for acceptance and then for valid_o.
  // Called at a falling edge; returns at the falling edge where valid_o is
  // first seen. lat counts cycles from the accept edge to valid_o.
  task automatic drive_op(input logic [7:0] u, input logic [8:0] v,
                          output logic [9:0] sum, output int lat,
                          output bit timed_out);
    int w;
    timed_out   = 1'b0;
    bus.u_i     = u;
    bus.v_i     = v;
    bus.valid_i = 1'b1;
    w = 0;
    while (!bus.ready_o && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready_o) timed_out = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.valid_o) timed_out = 1'b1;
    sum = bus.sum_o;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.valid_i = 1'b1;
    bus.u_i     = 8'h55;
    bus.v_i     = 9'h0AA;
    bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready_o);
    end
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o);
    end
    checks++;
    if (bus.sum_o !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_sum: got %h expected 000", bus.sum_o);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got ready=%b valid=%b expected ready=1 valid=0",
               bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_basic();
    logic [9:0] sum;
    int         lat;
    bit         to;
    bus.ready_i = 1'b1;
    drive_op(8'hFF, 9'h1FE, sum, lat, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL basic_timeout: got timeout expected valid_o within %0d cycles", TIMEOUT);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected 3", lat);
    end
    checks++;
    if (sum !== 10'h2FD) begin
      errors++;
      $display("[TB] FAIL basic_sum: got %h expected 2fd", sum);
    end
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ready_in_done: got %b expected 0", bus.ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_after_handshake: got ready=%b valid=%b expected ready=1 valid=0",
               bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_carry_boundary();
    logic [9:0] sum;
    int         lat;
    bit         to;
    bus.ready_i = 1'b1;
    drive_op(8'h0F, 9'h002, sum, lat, to);
    checks++;
    if (to || sum !== 10'h011) begin
      errors++;
      $display("[TB] FAIL carry_boundary: got %h (timeout=%b) expected 011", sum, to);
    end
    @(negedge clk);
  endtask

  task automatic test_ripple();
    logic [9:0] sum;
    int         lat;
    bit         to;
    bus.ready_i = 1'b1;
    drive_op(8'h00, 9'h000, sum, lat, to);
    checks++;
    if (to || sum !== 10'h000) begin
      errors++;
      $display("[TB] FAIL zero_sum: got %h (timeout=%b) expected 000", sum, to);
    end
    @(negedge clk);
    drive_op(8'hFF, 9'h001, sum, lat, to);
    checks++;
    if (to || sum !== 10'h100) begin
      errors++;
      $display("[TB] FAIL full_ripple: got %h (timeout=%b) expected 100", sum, to);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("[TB] FAIL ripple_latency: got %0d expected 3", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [9:0] sum;
    int         lat;
    int         w;
    bit         to;
    bus.ready_i = 1'b0;
    drive_op(8'h12, 9'h034, sum, lat, to);
    checks++;
    if (to || sum !== 10'h046) begin
      errors++;
      $display("[TB] FAIL bp_first_sum: got %h (timeout=%b) expected 046", sum, to);
    end
    bus.valid_i = 1'b1;
    bus.u_i     = 8'hAA;
    bus.v_i     = 9'h155;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.sum_o !== 10'h046 || bus.ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b sum=%h ready=%b expected valid=1 sum=046 ready=0",
                 i, bus.valid_o, bus.sum_o, bus.ready_o);
      end
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release_idle: got ready=%b valid=%b expected ready=1 valid=0",
               bus.ready_o, bus.valid_o);
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_second_accept: got ready=%b expected 0", bus.ready_o);
    end
    w = 0;
    while (!bus.valid_o && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.valid_o !== 1'b1 || bus.sum_o !== 10'h1FF) begin
      errors++;
      $display("[TB] FAIL bp_second_sum: got valid=%b sum=%h expected valid=1 sum=1ff",
               bus.valid_o, bus.sum_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] sum;
    int         lat;
    bit         to;
    bus.ready_i = 1'b1;
    bus.u_i     = 8'h33;
    bus.v_i     = 9'h044;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.sum_o !== 10'h000 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got valid=%b sum=%h ready=%b expected valid=0 sum=000 ready=1",
               bus.valid_o, bus.sum_o, bus.ready_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_op(8'h01, 9'h002, sum, lat, to);
    checks++;
    if (to || sum !== 10'h003 || lat != 3) begin
      errors++;
      $display("[TB] FAIL midrun_recover: got sum=%h lat=%0d timeout=%b expected sum=003 lat=3",
               sum, lat, to);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] x, y, z;
    logic [7:0] u;
    logic [8:0] v;
    logic [9:0] expected;
    logic [9:0] sum;
    int         lat;
    int         gap;
    bit         to;
    for (int n = 0; n < N_RANDOM; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      z = 8'($urandom);
      u = x ^ y ^ z;
      v = {(x & y) | (x & z) | (y & z), 1'b0};
      expected = 10'(x) + 10'(y) + 10'(z);
      bus.valid_i = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      bus.ready_i = (gap == 0);
      drive_op(u, v, sum, lat, to);
      checks++;
      if (to || sum !== expected) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h (timeout=%b) expected %h", n, sum, to, expected);
        if (to) return;
      end
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.sum_o !== expected) begin
          errors++;
          $display("[TB] FAIL random_hold_%0d: got valid=%b sum=%h expected valid=1 sum=%h",
                   n, bus.valid_o, bus.sum_o, expected);
        end
        bus.ready_i = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.u_i     = '0;
    bus.v_i     = '0;
    bus.ready_i = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry_boundary();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
